// File: rtl/tdm_pkg.sv
// Shared constants, state encoding and counter sizing helper for the 4-channel TDM transmitter.
package tdm_pkg;

    localparam int NCH    = 4;
    localparam int SLOT_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bit-counter width: clog2(width), never narrower than one bit.
    function automatic int cnt_w(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/tdm_tx_4ch_slot_counter.sv
// Bit/slot position counter for one TDM frame; wraps to slot 0, bit 0 after the last bit.
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CW = cnt_w(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    output logic [CW-1:0]     bit_cnt,
    output logic [SLOT_W-1:0] slot,
    output logic              last_bit
);

    localparam logic [CW-1:0]     BIT_LAST  = CW'(WIDTH - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NCH - 1);

    always_ff @(posedge clk) begin
        if (rst || load) begin
            bit_cnt <= '0;
            slot    <= '0;
        end else if (advance) begin
            if (bit_cnt == BIT_LAST) begin
                bit_cnt <= '0;
                slot    <= slot + 1'b1;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    assign last_bit = (slot == SLOT_LAST) && (bit_cnt == BIT_LAST);

endmodule

// File: rtl/tdm_tx_4ch.sv
// Four-channel TDM transmitter: serializes one 4-word frame, channel 0 first, MSB first,
// with frame sync and slot index outputs. Handshake: a frame transfers on any rising edge where din_valid && din_ready.
module tdm_tx_4ch
    import tdm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH*WIDTH-1:0]   din,
    input  logic                   din_valid,
    output logic                   din_ready,
    output logic                   tx_bit,
    output logic                   tx_sync,
    output logic [SLOT_W-1:0]      tx_slot,
    output logic                   tx_active
);

    localparam int FW = NCH * WIDTH;
    localparam int CW = cnt_w(WIDTH);

    state_t            state;
    state_t            state_nxt;
    logic              xfer;
    logic              advance;
    logic              last_bit;
    logic [CW-1:0]     bit_cnt;
    logic [FW-1:0]     ordered;
    logic [FW-1:0]     sreg;

    assign tx_active = (state == SHIFT);
    assign din_ready = !tx_active || last_bit;
    assign xfer      = din_valid && din_ready;
    assign advance   = tx_active && !xfer;

    // Place channel 0 in the top word so the frame leaves from the MSB end.
    always_comb begin
        ordered = '0;
        for (int n = 0; n < NCH; n++) begin
            ordered[(NCH-1-n)*WIDTH +: WIDTH] = din[n*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (xfer) state_nxt = SHIFT;
            SHIFT:   if (last_bit && !xfer) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // sreg holds the bits still to be sent after the one currently on tx_bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg    <= '0;
            tx_bit  <= 1'b0;
            tx_sync <= 1'b0;
        end else if (xfer) begin
            sreg    <= ordered << 1;
            tx_bit  <= ordered[FW-1];
            tx_sync <= 1'b1;
        end else if (advance) begin
            sreg    <= sreg << 1;
            tx_bit  <= last_bit ? 1'b0 : sreg[FW-1];
            tx_sync <= 1'b0;
        end
    end

    tdm_slot_counter #(
        .WIDTH(WIDTH)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .load    (xfer),
        .advance (advance),
        .bit_cnt (bit_cnt),
        .slot    (tx_slot),
        .last_bit(last_bit)
    );

endmodule
